// File: rtl/color_col_locator_if.sv
// Bus between the column locator, its source/destination pixel memories and
// the result consumers (display / LED driver).
interface color_col_locator_if #(
    parameter int c_nb_img_pxls = 13,
    parameter int c_nb_buf      = 12,
    parameter int c_nb_cols     = 7,
    parameter int c_nb_hist     = 6,
    parameter int c_nb_leds     = 8
);
    logic [c_nb_buf-1:0]      orig_pxl;
    logic [c_nb_img_pxls-1:0] orig_addr;
    logic                     proc_we;
    logic [c_nb_buf-1:0]      proc_pxl;
    logic [c_nb_img_pxls-1:0] proc_addr;
    logic [c_nb_cols-1:0]     ball_col;
    logic [c_nb_hist-1:0]     ball_cnt;
    logic                     ball_found;
    logic                     frame_done;
    logic [c_nb_leds-1:0]     leds;

    modport master (
        input  orig_pxl,
        output orig_addr, proc_we, proc_pxl, proc_addr,
        output ball_col, ball_cnt, ball_found, frame_done, leds
    );

    modport slave (
        output orig_pxl,
        input  orig_addr, proc_we, proc_pxl, proc_addr,
        input  ball_col, ball_cnt, ball_found, frame_done, leds
    );
endinterface

// File: rtl/color_col_locator.sv
// Threshold-filters a streamed image into a second memory and reports, once per
// frame, the column holding the most matching pixels.
module color_col_locator #(
    parameter int c_img_cols     = 80,
    parameter int c_img_rows     = 60,
    parameter int c_nb_img_pxls  = 13,
    parameter int c_nb_cols      = 7,
    parameter int c_nb_buf_red   = 4,
    parameter int c_nb_buf_green = 4,
    parameter int c_nb_buf_blue  = 4,
    parameter int c_nb_hist      = 6,
    parameter int c_nb_leds      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                rgbfilter,
    input  logic [c_nb_buf_red-1:0]   th_red,
    input  logic [c_nb_buf_green-1:0] th_green,
    input  logic [c_nb_buf_blue-1:0]  th_blue,
    input  logic [c_nb_hist-1:0]      min_count,
    color_col_locator_if.master       bus
);
    localparam int c_nb_buf = c_nb_buf_red + c_nb_buf_green + c_nb_buf_blue;
    localparam logic [c_nb_img_pxls-1:0] c_last_addr = c_nb_img_pxls'(c_img_cols * c_img_rows - 1);
    localparam logic [c_nb_cols-1:0]     c_last_col  = c_nb_cols'(c_img_cols - 1);
    localparam logic [c_nb_hist-1:0]     c_hist_max  = '1;

    localparam logic [1:0] S_SCAN   = 2'd0;
    localparam logic [1:0] S_FLUSH  = 2'd1;
    localparam logic [1:0] S_SEARCH = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    logic [1:0]                state_q, state_d;
    logic [c_nb_img_pxls-1:0]  addr_q, addr_d;
    logic [2:0]                filt_q;
    logic [c_nb_buf_red-1:0]   th_red_q;
    logic [c_nb_buf_green-1:0] th_green_q;
    logic [c_nb_buf_blue-1:0]  th_blue_q;
    logic                      wr_q;
    logic [c_nb_img_pxls-1:0]  wr_addr_q;
    logic [c_nb_cols-1:0]      col_q;
    logic [c_nb_cols-1:0]      idx_q, idx_d;
    logic [c_nb_cols-1:0]      max_col_q, max_col_d;
    logic [c_nb_hist-1:0]      max_q, max_d;
    logic [c_nb_hist-1:0]      bins_q [c_img_cols];

    logic [c_nb_cols-1:0]      ball_col_q, ball_col_d;
    logic [c_nb_hist-1:0]      ball_cnt_q, ball_cnt_d;
    logic                      ball_found_q, ball_found_d;
    logic [c_nb_leds-1:0]      leds_q, leds_d;
    logic                      done_q, done_d;

    logic [c_nb_buf_red-1:0]   red_s;
    logic [c_nb_buf_green-1:0] green_s;
    logic [c_nb_buf_blue-1:0]  blue_s;
    logic                      match_s;
    logic [c_nb_buf-1:0]       proc_pxl_s;
    logic [c_nb_hist-1:0]      bin_rd_s;
    logic [c_nb_hist-1:0]      cand_max_s;
    logic [c_nb_cols-1:0]      cand_col_s;

    // LED position scales the column onto the LED bar; column 0 lights the MSB.
    function automatic logic [c_nb_leds-1:0] led_onehot(input logic [c_nb_cols-1:0] col);
        logic [31:0]          pos;
        logic [c_nb_leds-1:0] one;
        one = {{(c_nb_leds-1){1'b0}}, 1'b1};
        pos = (32'(col) * 32'(c_nb_leds)) / 32'(c_img_cols);
        return one << (32'(c_nb_leds - 1) - pos);
    endfunction

    assign red_s   = bus.orig_pxl[c_nb_buf-1 -: c_nb_buf_red];
    assign green_s = bus.orig_pxl[c_nb_buf_green+c_nb_buf_blue-1 -: c_nb_buf_green];
    assign blue_s  = bus.orig_pxl[c_nb_buf_blue-1:0];

    // Match test against the frame's latched configuration.
    always_comb begin
        match_s = (filt_q != 3'b000)
                  && (!filt_q[2] || (red_s   >= th_red_q))
                  && (!filt_q[1] || (green_s >= th_green_q))
                  && (!filt_q[0] || (blue_s  >= th_blue_q));
    end

    // Write data pairs with the registered address: the read data arrives one cycle late.
    always_comb begin
        proc_pxl_s = '0;
        if (wr_q && ((filt_q == 3'b000) || match_s)) begin
            proc_pxl_s = bus.orig_pxl;
        end else begin
            proc_pxl_s = '0;
        end
    end

    // Running maximum candidate for the bin being read during SEARCH.
    always_comb begin
        bin_rd_s = bins_q[idx_q];
        if (bin_rd_s > max_q) begin
            cand_max_s = bin_rd_s;
            cand_col_s = idx_q;
        end else begin
            cand_max_s = max_q;
            cand_col_s = max_col_q;
        end
    end

    // Frame sequencer and result computation.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        idx_d        = idx_q;
        max_d        = max_q;
        max_col_d    = max_col_q;
        ball_col_d   = ball_col_q;
        ball_cnt_d   = ball_cnt_q;
        ball_found_d = ball_found_q;
        leds_d       = leds_q;
        done_d       = 1'b0;
        case (state_q)
            S_SCAN: begin
                if (addr_q == c_last_addr) begin
                    state_d = S_FLUSH;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + c_nb_img_pxls'(1);
                end
            end
            S_FLUSH: begin
                state_d   = S_SEARCH;
                idx_d     = '0;
                max_d     = '0;
                max_col_d = '0;
            end
            S_SEARCH: begin
                max_d     = cand_max_s;
                max_col_d = cand_col_s;
                if (idx_q == c_last_col) begin
                    state_d      = S_REPORT;
                    idx_d        = '0;
                    ball_cnt_d   = cand_max_s;
                    ball_col_d   = (cand_max_s == '0) ? '0 : cand_col_s;
                    ball_found_d = (cand_max_s != '0) && (cand_max_s >= min_count);
                    leds_d       = ball_found_d ? led_onehot(ball_col_d) : '0;
                    done_d       = 1'b1;
                end else begin
                    idx_d = idx_q + c_nb_cols'(1);
                end
            end
            S_REPORT: begin
                state_d = S_SCAN;
                addr_d  = '0;
            end
            default: begin
                state_d = S_SCAN;
                addr_d  = '0;
            end
        endcase
    end

    // Sequencer, config latch, write pipeline and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_SCAN;
            addr_q       <= '0;
            filt_q       <= '0;
            th_red_q     <= '0;
            th_green_q   <= '0;
            th_blue_q    <= '0;
            wr_q         <= 1'b0;
            wr_addr_q    <= '0;
            col_q        <= '0;
            idx_q        <= '0;
            max_q        <= '0;
            max_col_q    <= '0;
            ball_col_q   <= '0;
            ball_cnt_q   <= '0;
            ball_found_q <= 1'b0;
            leds_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            idx_q        <= idx_d;
            max_q        <= max_d;
            max_col_q    <= max_col_d;
            ball_col_q   <= ball_col_d;
            ball_cnt_q   <= ball_cnt_d;
            ball_found_q <= ball_found_d;
            leds_q       <= leds_d;
            done_q       <= done_d;
            if ((state_q == S_SCAN) && (addr_q == '0)) begin
                filt_q     <= rgbfilter;
                th_red_q   <= th_red;
                th_green_q <= th_green;
                th_blue_q  <= th_blue;
            end
            wr_q      <= (state_q == S_SCAN);
            wr_addr_q <= (state_q == S_SCAN) ? addr_q : '0;
            if (wr_q && (col_q != c_last_col)) begin
                col_q <= col_q + c_nb_cols'(1);
            end else begin
                col_q <= '0;
            end
        end
    end

    // Column histogram: saturating increments while writing, read-and-clear in SEARCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_img_cols; i++) begin
                bins_q[i] <= '0;
            end
        end else if (state_q == S_SEARCH) begin
            bins_q[idx_q] <= '0;
        end else if (wr_q && match_s && (bins_q[col_q] != c_hist_max)) begin
            bins_q[col_q] <= bins_q[col_q] + c_nb_hist'(1);
        end
    end

    assign bus.orig_addr  = addr_q;
    assign bus.proc_we    = wr_q;
    assign bus.proc_addr  = wr_addr_q;
    assign bus.proc_pxl   = proc_pxl_s;
    assign bus.ball_col   = ball_col_q;
    assign bus.ball_cnt   = ball_cnt_q;
    assign bus.ball_found = ball_found_q;
    assign bus.leds       = leds_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_color_col_locator.sv
// Scoreboard bench: each frame's expected writes and result are queued when the
// image is loaded; a monitor pops them as the DUT writes and reports.
module tb_color_col_locator;
    localparam int COLS = 80;
    localparam int ROWS = 60;
    localparam int P    = COLS * ROWS;

    typedef struct packed {
        logic [12:0] addr;
        logic [11:0] pxl;
    } wr_t;

    typedef struct packed {
        logic [6:0] col;
        logic [5:0] cnt;
        logic       found;
        logic [7:0] leds;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rgbfilter;
    logic [3:0] th_red, th_green, th_blue;
    logic [5:0] min_count;

    logic [11:0] img [0:P-1];
    wr_t  exp_wr[$];
    res_t exp_res[$];
    wr_t  mon_w;
    res_t mon_r;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   cyc0  = 0;
    int   wcnt  = 0;
    bit   was_reset;

    always #5 clk = ~clk;

    color_col_locator_if bus ();

    color_col_locator dut (
        .clk       (clk),
        .rst       (rst),
        .rgbfilter (rgbfilter),
        .th_red    (th_red),
        .th_green  (th_green),
        .th_blue   (th_blue),
        .min_count (min_count),
        .bus       (bus)
    );

    // Source memory: one-cycle synchronous read.
    always @(posedge clk) begin
        bus.orig_pxl <= img[bus.orig_addr];
        cyc          <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: filter every pixel, histogram by column, pick the first largest column.
    task automatic start_frame();
        int   hist [COLS];
        int   best, bcol, c;
        bit   m;
        logic [11:0] p;
        wr_t  w;
        res_t r;
        for (int i = 0; i < COLS; i++) hist[i] = 0;
        for (int a = 0; a < P; a++) begin
            p = img[a];
            m = (rgbfilter != 3'b000)
                && (!rgbfilter[2] || (p[11:8] >= th_red))
                && (!rgbfilter[1] || (p[7:4]  >= th_green))
                && (!rgbfilter[0] || (p[3:0]  >= th_blue));
            w.addr = 13'(a);
            w.pxl  = ((rgbfilter == 3'b000) || m) ? p : 12'h000;
            exp_wr.push_back(w);
            c = a % COLS;
            if (m && hist[c] < 63) hist[c]++;
        end
        best = 0;
        bcol = 0;
        for (int i = 0; i < COLS; i++) begin
            if (hist[i] > best) begin
                best = hist[i];
                bcol = i;
            end
        end
        r.cnt   = 6'(best);
        r.col   = 7'(bcol);
        r.found = (best != 0) && (best >= int'(min_count));
        r.leds  = r.found ? (8'b1000_0000 >> ((bcol * 8) / COLS)) : 8'h00;
        exp_res.push_back(r);
    endtask

    // Called at the negedge of REPORT: the next cycle is the new frame's cycle 0.
    task automatic next_frame();
        start_frame();
        cyc0 = cyc + 1;
    endtask

    // kind 0: plain frame; 1: switch filter to blue at address 2000; 2: reset at address 2000.
    task automatic wait_done(input int kind, output bit rst_hit);
        int n;
        bit seen;
        n       = 0;
        seen    = 1'b0;
        rst_hit = 1'b0;
        while (!seen && n < 6000) begin
            @(negedge clk);
            n++;
            if (kind != 0 && bus.orig_addr == 13'd2000) begin
                if (kind == 1) begin
                    rgbfilter = 3'b001;
                    kind      = 0;
                end else begin
                    rst = 1'b1;
                    exp_wr.delete();
                    exp_res.delete();
                    @(negedge clk);
                    chk("rst_orig_addr",  32'(bus.orig_addr), 32'd0);
                    chk("rst_proc_we",    32'(bus.proc_we), 32'd0);
                    chk("rst_proc_pxl",   32'(bus.proc_pxl), 32'd0);
                    chk("rst_proc_addr",  32'(bus.proc_addr), 32'd0);
                    chk("rst_ball_col",   32'(bus.ball_col), 32'd0);
                    chk("rst_ball_cnt",   32'(bus.ball_cnt), 32'd0);
                    chk("rst_ball_found", 32'(bus.ball_found), 32'd0);
                    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
                    chk("rst_leds",       32'(bus.leds), 32'd0);
                    rst_hit = 1'b1;
                    return;
                end
            end
            if (bus.frame_done) seen = 1'b1;
        end
        chk("frame_done_seen", 32'(seen), 32'd1);
        chk("frame_done_cycle", 32'(cyc - cyc0), 32'd4881);
    endtask

    // Monitor: pops and compares every write and every frame report.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            wcnt = 0;
        end else begin
            if (bus.proc_we) begin
                wcnt++;
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    mon_w = exp_wr.pop_front();
                    chk("proc_addr", 32'(bus.proc_addr), 32'(mon_w.addr));
                    chk("proc_pxl",  32'(bus.proc_pxl),  32'(mon_w.pxl));
                end
            end
            if (bus.frame_done) begin
                chk("writes_per_frame", 32'(wcnt), 32'(P));
                wcnt = 0;
                if (exp_res.size() == 0) begin
                    chk("unexpected_frame_done", 32'd1, 32'd0);
                end else begin
                    mon_r = exp_res.pop_front();
                    chk("ball_col",   32'(bus.ball_col),   32'(mon_r.col));
                    chk("ball_cnt",   32'(bus.ball_cnt),   32'(mon_r.cnt));
                    chk("ball_found", 32'(bus.ball_found), 32'(mon_r.found));
                    chk("leds",       32'(bus.leds),       32'(mon_r.leds));
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        rgbfilter = 3'b000;
        th_red    = 4'd0;
        th_green  = 4'd0;
        th_blue   = 4'd0;
        min_count = 6'd0;
        for (int a = 0; a < P; a++) img[a] = 12'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_orig_addr",  32'(bus.orig_addr), 32'd0);
        chk("reset_proc_we",    32'(bus.proc_we), 32'd0);
        chk("reset_proc_pxl",   32'(bus.proc_pxl), 32'd0);
        chk("reset_proc_addr",  32'(bus.proc_addr), 32'd0);
        chk("reset_ball_found", 32'(bus.ball_found), 32'd0);
        chk("reset_frame_done", 32'(bus.frame_done), 32'd0);
        chk("reset_leds",       32'(bus.leds), 32'd0);

        // Frame 1: all black, red filter.
        rgbfilter = 3'b100;
        th_red    = 4'd8;
        min_count = 6'd1;
        start_frame();
        cyc0 = cyc;
        rst  = 1'b0;
        wait_done(0, was_reset);

        // Frame 2: column 50 fully red.
        for (int a = 0; a < P; a++) img[a] = (a % COLS == 50) ? 12'hF00 : 12'h000;
        next_frame();
        wait_done(0, was_reset);

        // Frames 3/4: columns 10 and 30 with 20 red pixels each; tie goes to column 10.
        for (int a = 0; a < P; a++)
            img[a] = (((a % COLS == 10) || (a % COLS == 30)) && (a / COLS < 20)) ? 12'hF00 : 12'h000;
        next_frame();
        wait_done(0, was_reset);
        min_count = 6'd30;
        next_frame();
        wait_done(0, was_reset);

        // Frame 5: threshold edges on red+green, background never matches.
        rgbfilter = 3'b110;
        th_green  = 4'd8;
        min_count = 6'd1;
        for (int a = 0; a < P; a++) img[a] = 12'($urandom) & 12'h777;
        img[100] = 12'h780;
        img[101] = 12'h870;
        img[102] = 12'h880;
        next_frame();
        wait_done(0, was_reset);

        // Frame 6: pass-through on a random image.
        rgbfilter = 3'b000;
        for (int a = 0; a < P; a++) img[a] = 12'($urandom);
        next_frame();
        wait_done(0, was_reset);

        // Frame 7: red filter, switched to blue mid-frame; frame 8 then uses blue.
        rgbfilter = 3'b100;
        th_red    = 4'($urandom_range(8, 15));
        th_blue   = 4'($urandom_range(4, 15));
        for (int a = 0; a < P; a++) img[a] = 12'($urandom);
        next_frame();
        wait_done(1, was_reset);
        for (int a = 0; a < P; a++) img[a] = 12'($urandom);
        next_frame();
        wait_done(0, was_reset);

        // Frame 9: column 5 red, reset mid-frame; following frame has no red pixels.
        rgbfilter = 3'b100;
        th_red    = 4'd8;
        for (int a = 0; a < P; a++) img[a] = (a % COLS == 5) ? 12'hF00 : 12'h000;
        next_frame();
        wait_done(2, was_reset);
        chk("reset_taken", 32'(was_reset), 32'd1);
        for (int a = 0; a < P; a++) img[a] = 12'($urandom) & 12'h7FF;
        start_frame();
        cyc0 = cyc;
        rst  = 1'b0;
        wait_done(0, was_reset);

        @(negedge clk);
        @(negedge clk);
        chk("leftover_writes",  32'(exp_wr.size()), 32'd0);
        chk("leftover_results", 32'(exp_res.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/color_col_locator.md
# color_col_locator

Streams an image held in a pixel memory, applies a per-channel programmable threshold filter, and writes the filtered image to a second memory. It also builds a per-column histogram of matching pixels for each frame. At the end of each frame it reports the column holding the most matching pixels: its index, its count, a found flag, and a one-hot LED position. It sits between the camera frame buffer and the display/LED outputs, and is the parametrised successor of the fixed-threshold red column detector.

## Interface
Parameters:
- c_img_cols, 80, image width in pixels
- c_img_rows, 60, image height in pixels
- c_nb_img_pxls, 13, pixel address width (must hold cols*rows-1)
- c_nb_cols, 7, column index width (must hold cols-1)
- c_nb_buf_red / c_nb_buf_green / c_nb_buf_blue, 4 / 4 / 4, channel widths; pixel is {R,G,B}, R in the MSBs
- c_nb_hist, 6, histogram bin width; bins saturate
- c_nb_leds, 8, LED vector width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous and active-high
- rgbfilter  in  3  channel select {R,G,B}
- th_red / th_green / th_blue  in  channel width  per-channel minimum value
- min_count  in  c_nb_hist  minimum bin count for a valid detection
- orig_pxl  in  c_nb_buf  pixel read from the source memory
- orig_addr  out  c_nb_img_pxls  source read address
- proc_we  out  1  write enable for the destination memory
- proc_pxl  out  c_nb_buf  filtered pixel
- proc_addr  out  c_nb_img_pxls  destination write address
- ball_col  out  c_nb_cols  winning column
- ball_cnt  out  c_nb_hist  count in the winning column
- ball_found  out  1  detection valid
- frame_done  out  1  one-cycle pulse when results update
- leds  out  c_nb_leds  one-hot column position

## Operation
- FSM states:
  - SCAN: issues orig_addr 0..P-1, where P = cols*rows; goes to FLUSH after address P-1.
  - FLUSH: 1 cycle; processes the last pixel.
  - SEARCH: c_img_cols cycles.
  - REPORT: 1 cycle; returns to SCAN with address 0.
- Config latch: rgbfilter and the three thresholds are latched in the cycle orig_addr=0 is issued. Changes mid-frame take effect on the next frame only.
- Match rule: pixel matches if every channel selected in rgbfilter satisfies channel >= its threshold.
- rgbfilter=000 is pass-through mode: proc_pxl=orig_pxl and no pixel counts as a match.
- Filtered output: proc_pxl = orig_pxl if the pixel matches, else all zeros.
- Column tracking: an internal column counter follows the delayed address and wraps at c_img_cols-1. A matching pixel increments bin[column]; the increment saturates at 2^c_nb_hist-1.
- SEARCH: reads bin i for i = 0..cols-1.
  - Running max starts at 0; bin i replaces the max only if bin > max (strict), so the lowest column wins ties.
  - Each bin is cleared in the same cycle it is read.
- REPORT:
  - ball_cnt = max.
  - ball_col = column of the max, or 0 if max=0.
  - ball_found = (max != 0) and (max >= min_count).
  - leds: if found, only bit (c_nb_leds-1 - (ball_col*c_nb_leds)/c_img_cols) is set (column 0 is the MSB); if not found, all zeros.
  - frame_done = 1 for this cycle only.
- Result outputs hold their values until the next REPORT.
- Reset: state=SCAN, address 0, all bins cleared, latched config cleared. All outputs are 0: orig_addr, proc_we, proc_pxl, proc_addr, ball_*, frame_done, leds.

## Timing
- Source memory read latency is 1 cycle: address issued in cycle k, data valid in cycle k+1.
- Write pipeline: in cycle k+1, proc_addr=k and proc_we=1, and proc_pxl is registered from the pixel for address k.
- proc_we is 1 only in the SCAN cycles after the first and in FLUSH: exactly P write cycles per frame.
- orig_addr=0 outside SCAN.
- Frame period is P+cols+2 cycles; 4882 with default parameters.
- With rst released before cycle 0:
  - address P-1 is issued at cycle P-1;
  - FLUSH is at cycle P;
  - SEARCH covers cycles P+1..P+cols;
  - REPORT/frame_done is at cycle P+cols+1 (4881).
- Reset mid-frame: the cycle after rst deasserts issues address 0. Pre-reset pixels never contribute to a result.
- No histogram read/write conflict: FLUSH separates the last increment from the first SEARCH read.

## Test plan
- Reset, then all-black frame, rgbfilter=100, th_red=8, min_count=1 -> frame_done only at cycle 4881; ball_found=0, ball_cnt=0, ball_col=0, leds=00000000; exactly 4800 proc_we cycles, all proc_pxl=000.
- Column 50 fully red (F00), rest 000, rgbfilter=100, th_red=8 -> ball_col=50, ball_cnt=60, ball_found=1, leds=00000100; proc_pxl=F00 at addresses 50 mod 80.
- Columns 10 and 30 each with 20 red pixels, min_count=1 -> ball_col=10, ball_cnt=20, leds=01000000; then min_count=30 -> ball_found=0, ball_cnt=20, leds=00000000.
- Threshold edges, rgbfilter=110, th_red=8, th_green=8:
  - pixels 780 and 870 -> proc_pxl=000;
  - pixel 880 -> passes unchanged.
  - Then rgbfilter=000 -> every pixel is written unchanged and ball_found=0.
- Change rgbfilter from 100 to 001 at address 2000 -> the current frame still uses the red filter; the next frame uses blue.
- Assert rst for 1 cycle at address 2000 while column 5 has red pixels -> the next cycle issues orig_addr=0 and all outputs are 0. The following frame with no red pixels reports ball_found=0.
